// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encodings and the default operand width.
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_half_sub.sv
// Half-subtractor cell: diff = a ^ b, borrow = ~a & b.
module half_subtractor (
   input  logic a,
   input  logic b,
   output logic diff,
   output logic borrow
);

   assign diff   = a ^ b;
   assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-2:0] d_sr;
   logic             brw;
   logic [CW-1:0]    cnt;

   logic             hs1_d, hs1_b, d_bit, hs2_b, brw_nxt;
   logic [WIDTH-1:0] d_cat;

   // Full subtract = two half subtractors; their borrows never both fire.
   half_subtractor u_hs1 (
      .a      (a_sr[0]),
      .b      (b_sr[0]),
      .diff   (hs1_d),
      .borrow (hs1_b)
   );

   half_subtractor u_hs2 (
      .a      (hs1_d),
      .b      (brw),
      .diff   (d_bit),
      .borrow (hs2_b)
   );

   assign brw_nxt = hs1_b | hs2_b;
   assign d_cat   = {d_bit, d_sr};

`ifdef SERIAL_SUB_OVF_EN
   logic a_msb, b_msb;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         a_sr       <= '0;
         b_sr       <= '0;
         d_sr       <= '0;
         brw        <= 1'b0;
         cnt        <= '0;
`ifdef SERIAL_SUB_OVF_EN
         ovf        <= 1'b0;
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  brw   <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
`ifdef SERIAL_SUB_OVF_EN
                  a_msb <= a[WIDTH-1];
                  b_msb <= b[WIDTH-1];
`endif
               end
            end
            ST_RUN: begin
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               d_sr <= d_cat[WIDTH-1:1];
               brw  <= brw_nxt;
               cnt  <= cnt + CW'(1);
               // Final bit: publish the completed result in the same edge.
               if (cnt == LAST) begin
                  diff       <= d_cat;
                  borrow_out <= brw_nxt;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state      <= ST_DONE;
`ifdef SERIAL_SUB_OVF_EN
                  ovf        <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
`endif
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8); checks ovf when
// SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         busy, done, borrow_out;
   logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int errors = 0;
   int checks = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One operation: inputs change on negedge, outputs sampled on negedge.
   task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
      int lat, bcnt;
      @(negedge clk);
      start = 1'b1; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; a = ~av; b = ~bv;
      lat = 1; bcnt = 0;
      while (!done && lat < 20) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, lat, 9);
      chk({tag, "_busy_cycles"}, bcnt, 8);
      chk({tag, "_diff"}, diff, ed);
      chk({tag, "_borrow"}, borrow_out, eb);
`ifdef SERIAL_SUB_OVF_EN
      chk({tag, "_ovf"}, ovf, eo);
`else
      if (eo === 1'bx) $display("unused");
`endif
      @(negedge clk);
      chk({tag, "_done_width"}, done, 0);
   endtask

   initial begin
      int ndone, first, gap, last;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      chk("rst_borrow", borrow_out, 0);
      rst = 1'b0;
      @(negedge clk);

      do_op("p05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
      do_op("p03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
      do_op("p00_ff", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
      do_op("pa5_a5", 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);
      do_op("p80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      do_op("p7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

      // Second start during RUN must be ignored.
      @(negedge clk);
      start = 1'b1; a = 8'h10; b = 8'h01;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; a = 8'hFF; b = 8'h00;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 25; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      chk("ign_done_count", ndone, 1);
      chk("ign_diff", diff, 8'h0F);

      // Reset mid-RUN aborts with no done.
      start = 1'b1; a = 8'h80; b = 8'h01;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_before", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_diff", diff, 0);
      chk("abort_borrow", borrow_out, 0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      chk("abort_no_done", ndone, 0);
      do_op("after_abort", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

      // Continuous start: one op per WIDTH+2 cycles, single-cycle done.
      @(negedge clk);
      start = 1'b1; a = 8'h05; b = 8'h03;
      ndone = 0; first = -1; gap = 0; last = -1;
      for (int n = 1; n <= 35; n++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (first < 0) first = n;
            if (last == n - 1) gap = 1;
            last = n;
         end
      end
      start = 1'b0;
      chk("hold_done_count", ndone, 3);
      chk("hold_first_done", first, 9);
      chk("hold_last_done", last, 29);
      chk("hold_pulse_width", gap, 0);
      chk("hold_diff", diff, 8'h02);
      repeat (15) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
